aes_stream_feeder: RTL and testbench

AES_STREAM_FEEDER -- requirements
Module: aes_stream_feeder

---
 rtl/aes_stream_feeder.sv | 110 +++++++++++
 tb/tb_aes_stream_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_feeder.sv
// aes_stream_feeder: packs a 32-bit word stream into 128-bit blocks for an AES core and streams the ciphertext back out
module aes_stream_feeder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             key_ready,
    output logic [127:0]     core_plaintext,
    output logic             core_start,
    input  logic             core_done,
    input  logic [127:0]     core_ciphertext,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] block_count,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {LOAD, START, WAIT, SETTLE, UNLOAD} state_t;

    state_t         state, state_nx;
    logic [1:0]     idx;
    logic [TW-1:0]  timer;
    logic [127:0]   cap;
    logic           in_fire, out_fire, timed_out;

    assign out_data = cap[{~idx, 5'd0} +: 32];

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // next state and handshake/strobe outputs
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        busy       = state != LOAD;
        in_fire    = 1'b0;
        out_fire   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = key_ready && !reset;
                in_fire  = in_valid && in_ready;
                state_nx = (in_fire && idx == 2'd3) ? START : LOAD;
            end
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                timed_out = !core_done && timer == TW'(TIMEOUT - 1);
                state_nx  = core_done ? SETTLE : timed_out ? LOAD : WAIT;
            end
            SETTLE: state_nx = UNLOAD;
            UNLOAD: begin
                out_valid = 1'b1;
                out_fire  = out_ready;
                state_nx  = (out_fire && idx == 2'd3) ? LOAD : UNLOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // word index, plaintext shifter, wait timer, ciphertext capture and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            timer          <= '0;
            core_plaintext <= '0;
            cap            <= '0;
            block_count    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    core_plaintext <= {core_plaintext[95:0], in_data};
                    idx            <= idx + 2'd1;
                end
                START: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (timed_out) begin
                        timeout_err <= 1'b1;
                        idx         <= '0;
                    end
                end
                SETTLE: begin
                    cap <= core_ciphertext;
                    idx <= '0;
                end
                UNLOAD: if (out_fire) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) block_count <= block_count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_stream_feeder.sv
// tb_aes_stream_feeder: scoreboard bench for aes_stream_feeder with a behavioural AES core stand-in
module tb_aes_stream_feeder;
    localparam logic [127:0] AES_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid, in_ready, key_ready;
    logic [127:0] core_plaintext, core_ciphertext;
    logic         core_start, core_done;
    logic [31:0]  out_data;
    logic         out_valid, out_ready, busy, timeout_err;
    logic [1:0]   block_count;

    int           n_chk = 0, n_fail = 0, starts = 0;
    logic [31:0]  q[$];
    bit           core_hang = 0, use_pat = 0, pending = 0;
    int           lat_cnt = 0, pi = 0;
    logic [127:0] ptq;
    bit           pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    bit           prev_hold = 0;
    logic [31:0]  prev_data;

    aes_stream_feeder #(.CNT_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .key_ready(key_ready), .core_plaintext(core_plaintext), .core_start(core_start),
        .core_done(core_done), .core_ciphertext(core_ciphertext), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .block_count(block_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] cipher(input logic [127:0] pt);
        return (pt == AES_PT) ? AES_CT : ~pt;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // core stand-in: answers six cycles after start unless hung
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) pending <= 0;
        else if (core_start) begin
            pending <= 1; lat_cnt <= 0; ptq <= core_plaintext;
        end else if (pending && !core_hang) begin
            if (lat_cnt == 5) begin
                core_done <= 1'b1; core_ciphertext <= cipher(ptq); pending <= 0;
            end else lat_cnt <= lat_cnt + 1;
        end
    end

    // monitor: scoreboard pops, output hold, input gating, start pulses
    always @(negedge clk) begin
        if (core_start) starts++;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", out_data, 'x);
                else chk("out_word", out_data, q.pop_front());
            end
            if (prev_hold && out_valid) chk("out_hold", out_data, prev_data);
            chk("in_ready_gate", in_ready, !busy && key_ready);
        end
        prev_hold = out_valid && !out_ready && !reset;
        prev_data = out_data;
    end

    // out_ready pattern player, advancing only while output is offered
    initial forever begin
        @(posedge clk); #1;
        if (use_pat && out_valid) begin
            out_ready = pat[pi % 7]; pi++;
        end
    end

    task automatic send_word(input logic [31:0] d);
        int n = 0; bit ok = 0;
        in_data = d; in_valid = 1;
        while (!ok && n < 300) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_block(input logic [127:0] pt, input bit expect_out);
        if (expect_out) for (int i = 3; i >= 0; i--) q.push_back(cipher(pt)[i*32 +: 32]);
        for (int i = 3; i >= 0; i--) send_word(pt[i*32 +: 32]);
        in_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 1000) begin @(posedge clk); n++; end
        #1;
        chk("idle_reached", n < 1000, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1; #2;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", block_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_pt", core_plaintext, 0);
        @(posedge clk); #1 reset = 0; starts = 0; q.delete();
    endtask

    initial begin
        int n;
        reset = 1; in_valid = 0; in_data = 0; key_ready = 0; out_ready = 1;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", block_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_pt", core_plaintext, 0);
        repeat (2) @(posedge clk); #1 reset = 0;

        // key not ready: nothing consumed for 20 cycles, then accepted on the next edge
        in_valid = 1; in_data = 32'h00112233;
        repeat (20) @(posedge clk); #1;
        chk("no_consume", core_plaintext, 0);
        for (int i = 3; i >= 0; i--) q.push_back(AES_CT[i*32 +: 32]);
        key_ready = 1;
        @(posedge clk); #1;
        chk("first_accept", core_plaintext, 128'h00112233);
        send_word(32'h44556677); send_word(32'h8899aabb); send_word(32'hccddeeff);
        in_valid = 0;
        wait_idle();
        chk("count_1", block_count, 1);
        chk("starts_1", starts, 1);

        // back-pressure pattern on the output
        use_pat = 1; pi = 0;
        send_block(AES_PT, 1);
        wait_idle();
        use_pat = 0; out_ready = 1;
        chk("count_2", block_count, 2);
        chk("starts_2", starts, 2);

        // reset after two words, then a clean block
        send_word(32'h00112233); send_word(32'h44556677); in_valid = 0;
        pulse_reset();
        send_block(AES_PT, 1);
        wait_idle();
        chk("count_after_rst", block_count, 1);
        chk("starts_after_rst", starts, 1);

        // counter wrap with a 2-bit counter
        send_block(128'h0123456789abcdef0011223344556677, 1); wait_idle();
        send_block(128'hdeadbeefcafef00d1234567890abcdef, 1); wait_idle();
        chk("count_3", block_count, 3);
        send_block(128'h11111111222222223333333344444444, 1); wait_idle();
        chk("wrap_0", block_count, 0);
        send_block(128'hffffffff000000005a5a5a5aa5a5a5a5, 1); wait_idle();
        chk("wrap_1", block_count, 1);
        send_block(128'h80000000000000010000000100000000, 1); wait_idle();
        chk("wrap_2", block_count, 2);

        // reset in the middle of unloading produces no further words
        out_ready = 0;
        send_block(AES_PT, 1);
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("unload_reached", out_valid, 1);
        out_ready = 1;
        @(posedge clk); #1;
        pulse_reset();
        repeat (10) @(posedge clk); #1;
        chk("no_out_after_rst", out_valid, 0);
        chk("count_after_unload_rst", block_count, 0);

        // hung core: 1 START + 64 WAIT cycles, then back to LOAD with the error flag
        core_hang = 1;
        send_block(AES_PT, 0);
        n = 0;
        while (busy && n < 300) begin @(negedge clk); if (busy) n++; end
        chk("busy_cycles", n, 65);
        chk("terr_set", timeout_err, 1);
        chk("count_unchanged", block_count, 0);
        // late completion arriving in LOAD must be ignored
        core_hang = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); chk("ignore_done", busy, 0); end
        @(posedge clk); #1;
        send_block(AES_PT, 1);
        wait_idle();
        chk("count_after_to", block_count, 1);
        chk("terr_sticky", timeout_err, 1);
        pulse_reset();
        chk("terr_cleared", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
